// File: rtl/slurm16_mem_defs_pkg.sv
// Shared definitions for the slurm16 data-memory access stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package slurm16_mem_defs;

  // Access FSM: IDLE issues straight from stage 3, WAIT replays the held request.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Little-endian byte-lane masks.
  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_WORD = 2'b11;

endpackage

// File: rtl/slurm16_mem_lane_steer.sv
// Lane steering: byte address/size/store data -> word address, lane mask, write data.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module slurm16_mem_lane_steer #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    req_byte,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [BITS-1:0]         req_store_data,
  output logic [ADDRESS_BITS-2:0] steer_addr,
  output logic [1:0]              steer_mask,
  output logic [BITS-1:0]         steer_wdata,
  output logic                    misaligned_comb
);
  import slurm16_mem_defs::*;

  // Word address drops bit 0; byte accesses pick a lane and replicate the byte.
  always_comb begin
    steer_addr      = req_address[ADDRESS_BITS-1:1];
    steer_mask      = MASK_WORD;
    steer_wdata     = req_store_data;
    misaligned_comb = 1'b0;
    if (req_byte) begin
      steer_mask  = req_address[0] ? MASK_HI : MASK_LO;
      steer_wdata = {(BITS/8){req_store_data[7:0]}};
    end else begin
      misaligned_comb = req_address[0];
    end
  end

endmodule

// File: rtl/slurm16_cpu_memory_stage.sv
// Stage-3 data-memory access: issues load/store on a valid/ready bus, aligns results to stage 4.
// Latency: request accepted in cycle N -> memory_in / mask at writeback in cycle N+1.
// Backpressure: stall asserted while an issued request is not yet accepted; request held stable.
module slurm16_cpu_memory_stage #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  input  logic                    req_store,
  input  logic                    req_byte,
  input  logic                    req_bank,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [BITS-1:0]         req_store_data,
  input  logic                    flush,
  output logic                    stall,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic                    bus_wr,
  output logic                    bus_bank,
  output logic [ADDRESS_BITS-2:0] bus_addr,
  output logic [1:0]              bus_wr_mask,
  output logic [BITS-1:0]         bus_wdata,
  input  logic [BITS-1:0]         bus_rdata,
  output logic [BITS-1:0]         memory_in,
  output logic [1:0]              memory_wr_mask_delayed,
  output logic                    misaligned
);
  import slurm16_mem_defs::*;

  logic [ADDRESS_BITS-2:0] steer_addr;
  logic [1:0]              steer_mask;
  logic [BITS-1:0]         steer_wdata;
  logic                    steer_misaligned;

  mem_state_e              state_q, state_d;
  logic                    hold_wr_q, hold_wr_d;
  logic                    hold_bank_q, hold_bank_d;
  logic                    hold_mis_q, hold_mis_d;
  logic [ADDRESS_BITS-2:0] hold_addr_q, hold_addr_d;
  logic [1:0]              hold_mask_q, hold_mask_d;
  logic [BITS-1:0]         hold_wdata_q, hold_wdata_d;
  logic                    resp_q, resp_d;
  logic [1:0]              mask_dly_q, mask_dly_d;
  logic                    mis_q, mis_d;
  logic [BITS-1:0]         rdata_q, rdata_d;

  logic                    cur_mis;
  logic                    accept;

  slurm16_mem_lane_steer #(
    .BITS         (BITS),
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_lane_steer (
    .req_byte        (req_byte),
    .req_address     (req_address),
    .req_store_data  (req_store_data),
    .steer_addr      (steer_addr),
    .steer_mask      (steer_mask),
    .steer_wdata     (steer_wdata),
    .misaligned_comb (steer_misaligned)
  );

  // Bus drive: held request in WAIT, live stage-3 request in IDLE (quiet while in reset or flushed).
  always_comb begin
    bus_valid   = 1'b0;
    bus_wr      = 1'b0;
    bus_bank    = 1'b0;
    bus_addr    = '0;
    bus_wr_mask = MASK_NONE;
    bus_wdata   = '0;
    cur_mis     = 1'b0;
    if (state_q == WAIT) begin
      bus_valid   = 1'b1;
      bus_wr      = hold_wr_q;
      bus_bank    = hold_bank_q;
      bus_addr    = hold_addr_q;
      bus_wr_mask = hold_mask_q;
      bus_wdata   = hold_wdata_q;
      cur_mis     = hold_mis_q;
    end else if (req_valid && !flush && !RST) begin
      bus_valid   = 1'b1;
      bus_wr      = req_store;
      bus_bank    = req_bank;
      bus_addr    = steer_addr;
      bus_wr_mask = steer_mask;
      bus_wdata   = steer_wdata;
      cur_mis     = steer_misaligned;
    end
    accept = bus_valid && bus_ready;
    stall  = bus_valid && !bus_ready;
  end

  // Next state: capture a refused IDLE request, release on acceptance, stage the response.
  always_comb begin
    state_d      = state_q;
    hold_wr_d    = hold_wr_q;
    hold_bank_d  = hold_bank_q;
    hold_mis_d   = hold_mis_q;
    hold_addr_d  = hold_addr_q;
    hold_mask_d  = hold_mask_q;
    hold_wdata_d = hold_wdata_q;
    if (state_q == IDLE) begin
      if (bus_valid && !bus_ready) begin
        state_d      = WAIT;
        hold_wr_d    = bus_wr;
        hold_bank_d  = bus_bank;
        hold_mis_d   = cur_mis;
        hold_addr_d  = bus_addr;
        hold_mask_d  = bus_wr_mask;
        hold_wdata_d = bus_wdata;
      end
    end else if (bus_ready) begin
      state_d = IDLE;
    end
    resp_d     = accept;
    mask_dly_d = (accept && !bus_wr) ? bus_wr_mask : MASK_NONE;
    mis_d      = accept && cur_mis;
    rdata_d    = resp_q ? bus_rdata : rdata_q;
  end

  // Read data is forwarded live during the response cycle and held afterwards.
  assign memory_in              = resp_q ? bus_rdata : rdata_q;
  assign memory_wr_mask_delayed = mask_dly_q;
  assign misaligned             = mis_q;

  // All stage state, cleared asynchronously so a reset in WAIT drops the bus at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      hold_wr_q    <= 1'b0;
      hold_bank_q  <= 1'b0;
      hold_mis_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_mask_q  <= MASK_NONE;
      hold_wdata_q <= '0;
      resp_q       <= 1'b0;
      mask_dly_q   <= MASK_NONE;
      mis_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_wr_q    <= hold_wr_d;
      hold_bank_q  <= hold_bank_d;
      hold_mis_q   <= hold_mis_d;
      hold_addr_q  <= hold_addr_d;
      hold_mask_q  <= hold_mask_d;
      hold_wdata_q <= hold_wdata_d;
      resp_q       <= resp_d;
      mask_dly_q   <= mask_dly_d;
      mis_q        <= mis_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_slurm16_cpu_memory_stage.sv
// Directed bench for the slurm16 memory stage with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled mid-cycle.
// Backpressure: bus_ready driven directly by the stimulus.
module tb_slurm16_cpu_memory_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_store, req_byte, req_bank;
  logic [15:0] req_address, req_store_data;
  logic        flush;
  logic        stall, bus_valid, bus_ready, bus_wr, bus_bank;
  logic [14:0] bus_addr;
  logic [1:0]  bus_wr_mask;
  logic [15:0] bus_wdata, bus_rdata, memory_in;
  logic [1:0]  memory_wr_mask_delayed;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  slurm16_cpu_memory_stage #(.BITS(16), .ADDRESS_BITS(16)) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .req_valid              (req_valid),
    .req_store              (req_store),
    .req_byte               (req_byte),
    .req_bank               (req_bank),
    .req_address            (req_address),
    .req_store_data         (req_store_data),
    .flush                  (flush),
    .stall                  (stall),
    .bus_valid              (bus_valid),
    .bus_ready              (bus_ready),
    .bus_wr                 (bus_wr),
    .bus_bank               (bus_bank),
    .bus_addr               (bus_addr),
    .bus_wr_mask            (bus_wr_mask),
    .bus_wdata              (bus_wdata),
    .bus_rdata              (bus_rdata),
    .memory_in              (memory_in),
    .memory_wr_mask_delayed (memory_wr_mask_delayed),
    .misaligned             (misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic by, input logic bk,
                           input logic [15:0] a, input logic [15:0] d);
    req_valid      = 1'b1;
    req_store      = st;
    req_byte       = by;
    req_bank       = bk;
    req_address    = a;
    req_store_data = d;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; bus_ready = 1'b1; bus_rdata = 16'h0;
    drive_req(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0);
    tick(); #3;
    // Reset values, with a live request present that must not leak out.
    chk("rst_stall", stall, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_wr", bus_wr, 0);
    chk("rst_bus_bank", bus_bank, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wr_mask", bus_wr_mask, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_memory_in", memory_in, 0);
    chk("rst_mask_dly", memory_wr_mask_delayed, 0);
    chk("rst_misaligned", misaligned, 0);
    tick();
    RST = 1'b0;

    // Word load at 0x1234 accepted immediately.
    drive_req(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0);
    #3;
    chk("ld_valid", bus_valid, 1);
    chk("ld_addr", bus_addr, 15'h091A);
    chk("ld_mask", bus_wr_mask, 2'b11);
    chk("ld_wr", bus_wr, 0);
    chk("ld_stall", stall, 0);
    tick();
    req_valid = 1'b0; bus_rdata = 16'hBEEF;
    #1;
    chk("ld_memory_in", memory_in, 16'hBEEF);
    chk("ld_mask_dly", memory_wr_mask_delayed, 2'b11);
    chk("ld_misaligned", misaligned, 0);
    tick();
    bus_rdata = 16'h1111;
    #1;
    chk("ld_memory_in_hold", memory_in, 16'hBEEF);
    chk("ld_mask_dly_clear", memory_wr_mask_delayed, 2'b00);

    // Byte store at odd address: upper lane, replicated byte.
    drive_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h00A5);
    #2;
    chk("stb_wr", bus_wr, 1);
    chk("stb_mask", bus_wr_mask, 2'b10);
    chk("stb_wdata", bus_wdata, 16'hA5A5);
    chk("stb_addr", bus_addr, 15'h0008);
    tick();
    req_valid = 1'b0;
    #1;
    chk("stb_mask_dly", memory_wr_mask_delayed, 2'b00);
    chk("stb_misaligned", misaligned, 0);

    // Word store passes data unmodified; byte store at even address uses lower lane.
    tick();
    drive_req(1'b1, 1'b0, 1'b0, 16'h0040, 16'hCAFE);
    #3;
    chk("st_wdata", bus_wdata, 16'hCAFE);
    chk("st_mask", bus_wr_mask, 2'b11);
    tick();
    drive_req(1'b1, 1'b1, 1'b0, 16'h0042, 16'h1234);
    #3;
    chk("stb_lo_wdata", bus_wdata, 16'h3434);
    chk("stb_lo_mask", bus_wr_mask, 2'b01);
    tick();
    req_valid = 1'b0;

    // Upper-bank load refused for 3 cycles, stage-3 inputs turn to garbage meanwhile.
    tick();
    drive_req(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0);
    bus_ready = 1'b0;
    #3;
    chk("wt1_stall", stall, 1);
    chk("wt1_valid", bus_valid, 1);
    chk("wt1_addr", bus_addr, 15'h0080);
    tick();
    drive_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hDEAD);
    #3;
    chk("wt2_stall", stall, 1);
    chk("wt2_addr", bus_addr, 15'h0080);
    chk("wt2_wr", bus_wr, 0);
    chk("wt2_bank", bus_bank, 1);
    chk("wt2_mask", bus_wr_mask, 2'b11);
    chk("wt2_mask_dly", memory_wr_mask_delayed, 2'b00);
    tick();
    flush = 1'b1;
    #3;
    chk("wt3_stall", stall, 1);
    chk("wt3_valid_flush", bus_valid, 1);
    chk("wt3_addr", bus_addr, 15'h0080);
    tick();
    bus_ready = 1'b1;
    #3;
    chk("wt4_stall", stall, 0);
    chk("wt4_valid", bus_valid, 1);
    chk("wt4_addr", bus_addr, 15'h0080);
    tick();
    req_valid = 1'b0; flush = 1'b0; bus_rdata = 16'h5A5A;
    #1;
    chk("wt5_memory_in", memory_in, 16'h5A5A);
    chk("wt5_mask_dly", memory_wr_mask_delayed, 2'b11);
    chk("wt5_valid", bus_valid, 0);

    // Flushed byte load: no bus activity at all.
    tick();
    drive_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
    flush = 1'b1;
    #3;
    chk("fl_valid", bus_valid, 0);
    chk("fl_stall", stall, 0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("fl_mask_dly", memory_wr_mask_delayed, 2'b00);

    // Misaligned word load at 0x0003.
    drive_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0);
    #3;
    chk("mis_addr", bus_addr, 15'h0001);
    chk("mis_mask", bus_wr_mask, 2'b11);
    chk("mis_early", misaligned, 0);
    tick();
    req_valid = 1'b0;
    #1;
    chk("mis_pulse", misaligned, 1);
    chk("mis_mask_dly", memory_wr_mask_delayed, 2'b11);
    tick();
    chk("mis_pulse_end", misaligned, 0);

    // Back-to-back: word load then byte load in consecutive cycles.
    drive_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
    tick();
    drive_req(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0);
    bus_rdata = 16'h1234;
    #2;
    chk("b2b_mem_in0", memory_in, 16'h1234);
    chk("b2b_mask_dly0", memory_wr_mask_delayed, 2'b11);
    chk("b2b_valid1", bus_valid, 1);
    chk("b2b_stall1", stall, 0);
    chk("b2b_addr1", bus_addr, 15'h0010);
    chk("b2b_mask1", bus_wr_mask, 2'b10);
    tick();
    req_valid = 1'b0; bus_rdata = 16'hAB00;
    #1;
    chk("b2b_mem_in1", memory_in, 16'hAB00);
    chk("b2b_mask_dly1", memory_wr_mask_delayed, 2'b10);

    // Reset asserted between edges while waiting.
    tick();
    drive_req(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0);
    bus_ready = 1'b0;
    tick();
    #1;
    chk("rw_valid_pre", bus_valid, 1);
    chk("rw_stall_pre", stall, 1);
    #1;
    RST = 1'b1;
    #1;
    chk("rw_valid", bus_valid, 0);
    chk("rw_stall", stall, 0);
    chk("rw_addr", bus_addr, 0);
    chk("rw_memory_in", memory_in, 0);
    tick();
    RST = 1'b0; bus_ready = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 16'h0300, 16'h0);
    #3;
    chk("rw_post_valid", bus_valid, 1);
    chk("rw_post_addr", bus_addr, 15'h0180);
    chk("rw_post_stall", stall, 0);
    tick();
    req_valid = 1'b0; bus_rdata = 16'h7777;
    #1;
    chk("rw_post_mem_in", memory_in, 16'h7777);
    chk("rw_post_mask_dly", memory_wr_mask_delayed, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
